// File: rtl/cap_sense_pkg.sv
// Shared types and constants for the capacitive-sensing path (scanner and execute-stage decode).
package cap_sense_pkg;

  localparam int unsigned READING_W    = 32;
  localparam int unsigned NUM_PADS_DEF = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    CHARGE    = 2'd2,
    STORE     = 2'd3
  } scan_state_e;

  // LSB of pad slot i on the packed readings bus.
  function automatic int unsigned slot_lsb(input int unsigned pad);
    return pad * READING_W;
  endfunction

endpackage

// File: rtl/cap_pad_sync.sv
// WIDTH-bit two-flop synchronizer for the raw asynchronous pad levels.
module cap_pad_sync #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cap_sense_scanner.sv
// Sequential RC charge-time scanner over NUM_PADS touch pads.
// Define CAP_FILTER_EN to blend each new reading into its slot as (3*old + new) >> 2.
module cap_sense_scanner
  import cap_sense_pkg::*;
#(
  parameter int unsigned NUM_PADS         = NUM_PADS_DEF,
  parameter int unsigned DISCHARGE_CYCLES = 64,
  parameter int unsigned COUNT_MAX        = 65535
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          scan_enable,
  input  logic [NUM_PADS-1:0]           pad_in,
  output logic [NUM_PADS-1:0]           pad_discharge,
  output logic [READING_W*NUM_PADS-1:0] sensor_readings,
  output logic [3:0]                    pad_index,
  output logic                          scan_done
);

  localparam logic [31:0] DIS_LAST = 32'(DISCHARGE_CYCLES - 1);
  localparam logic [31:0] CNT_MAX  = 32'(COUNT_MAX);
  localparam logic [3:0]  LAST_PAD = 4'(NUM_PADS - 1);

  logic [NUM_PADS-1:0]  pad_s;
  scan_state_e          state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [NUM_PADS-1:0]  dis_q, dis_d;
  logic                 done_q;
  logic                 last_store;
  logic [READING_W-1:0] slot_q [NUM_PADS];

`ifdef CAP_FILTER_EN
  logic [NUM_PADS-1:0]  valid_q;
  logic                 wr_q;
  logic [3:0]           wr_idx_q;
  logic [31:0]          wr_val_q;
  logic                 done_pipe_q;
  logic [31:0]          blend;

  assign blend = 32'((34'(slot_q[wr_idx_q]) * 34'd3 + 34'(wr_val_q)) >> 2);
`endif

  cap_pad_sync #(.WIDTH(NUM_PADS)) u_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (pad_in),
    .q_o   (pad_s)
  );

  assign last_store = (state_q == STORE) && (idx_q == LAST_PAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (scan_enable) begin
          state_d = DISCHARGE;
          cnt_d   = '0;
        end
      end
      DISCHARGE: begin
        if (cnt_q == DIS_LAST) begin
          state_d = CHARGE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      CHARGE: begin
        if (pad_s[idx_q] || (cnt_q == CNT_MAX)) state_d = STORE;
        else                                     cnt_d   = cnt_q + 32'd1;
      end
      STORE: begin
        cnt_d = '0;
        if (idx_q == LAST_PAD) begin
          idx_d   = '0;
          state_d = scan_enable ? DISCHARGE : IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = DISCHARGE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Discharge drive is registered from the next state so the pad releases exactly in CHARGE.
  always_comb begin
    dis_d = '1;
    if (state_d == CHARGE) dis_d[idx_d] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dis_q   <= '1;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_PADS; i++) slot_q[i] <= '0;
`ifdef CAP_FILTER_EN
      valid_q     <= '0;
      wr_q        <= 1'b0;
      wr_idx_q    <= '0;
      wr_val_q    <= '0;
      done_pipe_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dis_q   <= dis_d;
`ifdef CAP_FILTER_EN
      // Extra stage: capture the raw store, blend next cycle; done follows to stay aligned.
      wr_q        <= (state_q == STORE);
      wr_idx_q    <= idx_q;
      wr_val_q    <= cnt_q;
      done_pipe_q <= last_store;
      done_q      <= done_pipe_q;
      if (wr_q) begin
        slot_q[wr_idx_q]  <= valid_q[wr_idx_q] ? blend : wr_val_q;
        valid_q[wr_idx_q] <= 1'b1;
      end
`else
      done_q <= last_store;
      if (state_q == STORE) slot_q[idx_q] <= cnt_q;
`endif
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_slot
    assign sensor_readings[slot_lsb(g) +: READING_W] = slot_q[g];
  end

  assign pad_discharge = dis_q;
  assign pad_index     = idx_q;
  assign scan_done     = done_q;

endmodule

// File: tb/tb_cap_sense_scanner.sv
// Self-checking bench for cap_sense_scanner with a behavioural pad model and per-sweep reading model.
module tb_cap_sense_scanner;

  localparam int NP = 9;
  localparam int DC = 4;
  localparam int CM = 100;

  logic            clock = 1'b0;
  logic            reset;
  logic            scan_enable;
  logic [NP-1:0]   pad_in;
  logic [NP-1:0]   pad_discharge;
  logic [32*NP-1:0] sensor_readings;
  logic [3:0]      pad_index;
  logic            scan_done;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_RISE, M_NEVER, M_HIGH} mode_e;
  mode_e       mode  [NP];
  int          dly   [NP];
  int          rel   [NP];
  logic [31:0] model_slot  [NP];
  bit          model_valid [NP];
  int          done_cnt  = 0;
  int          disc_viol = 0;
  int          rel0      = 0;

  cap_sense_scanner #(
    .NUM_PADS         (NP),
    .DISCHARGE_CYCLES (DC),
    .COUNT_MAX        (CM)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .scan_enable     (scan_enable),
    .pad_in          (pad_in),
    .pad_discharge   (pad_discharge),
    .sensor_readings (sensor_readings),
    .pad_index       (pad_index),
    .scan_done       (scan_done)
  );

  initial forever #5 clock = ~clock;

  // Pad model: a released RISE pad goes high dly cycles after release; monitors ride along.
  initial begin
    logic [NP-1:0] one_hot;
    pad_in = '0;
    for (int p = 0; p < NP; p++) rel[p] = 0;
    forever begin
      @(negedge clock);
      for (int p = 0; p < NP; p++) begin
        if (pad_discharge[p] !== 1'b0) rel[p] = 0;
        else                           rel[p] = rel[p] + 1;
        case (mode[p])
          M_HIGH:  pad_in[p] = 1'b1;
          M_NEVER: pad_in[p] = 1'b0;
          default: pad_in[p] = (pad_discharge[p] === 1'b0) && (rel[p] > dly[p]);
        endcase
      end
      if (scan_done === 1'b1) done_cnt++;
      one_hot = '0;
      if (pad_index < NP) one_hot[pad_index] = 1'b1;
      if (reset === 1'b0 && (((pad_discharge | one_hot) !== '1) || pad_index >= NP)) disc_viol++;
      if (pad_discharge[0] === 1'b0) rel0++;
    end
  end

  function automatic logic [31:0] get_slot(input int p);
    return sensor_readings[p*32 +: 32];
  endfunction

  function automatic int exp_raw(input int p);
    case (mode[p])
      M_HIGH:  return 0;
      M_NEVER: return CM;
      default: return (dly[p] + 2 > CM) ? CM : dly[p] + 2;
    endcase
  endfunction

  task automatic model_sweep();
    for (int p = 0; p < NP; p++) begin
`ifdef CAP_FILTER_EN
      if (model_valid[p]) model_slot[p] = 32'((3 * longint'(model_slot[p]) + longint'(exp_raw(p))) / 4);
      else                model_slot[p] = 32'(exp_raw(p));
`else
      model_slot[p] = 32'(exp_raw(p));
`endif
      model_valid[p] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      model_slot[p]  = '0;
      model_valid[p] = 1'b0;
    end
  endtask

  task automatic randomize_pads();
    for (int p = 0; p < NP; p++) begin
      mode[p] = M_RISE;
      dly[p]  = int'($urandom_range(0, 30));
    end
  endtask

  task automatic pulse_enable();
    @(negedge clock) scan_enable = 1'b1;
    @(negedge clock) scan_enable = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_done(output bit ok, output logic [31:0] prev8, output logic [31:0] cur8);
    ok    = 1'b0;
    cur8  = get_slot(8);
    prev8 = cur8;
    for (int i = 0; i < 4000; i++) begin
      prev8 = cur8;
      @(negedge clock);
      cur8 = get_slot(8);
      if (scan_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    if (pad_discharge !== 9'h1FF) begin errors++; $display("FAIL rst_discharge: got %h expected 1ff", pad_discharge); end
    checks++;
    if (pad_index !== 4'd0) begin errors++; $display("FAIL rst_index: got %0d expected 0", pad_index); end
    checks++;
    if (sensor_readings !== '0) begin errors++; $display("FAIL rst_readings: got %h expected 0", sensor_readings); end
    checks++;
    if (scan_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", scan_done); end
    checks++;
  endtask

  task automatic test_reset_mid_charge();
    bit ok = 1'b0;
    randomize_pads();
    mode[3] = M_NEVER;
    @(negedge clock) scan_enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (pad_index === 4'd3 && pad_discharge[3] === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) begin errors++; $display("FAIL midrst_reach_pad3: got timeout expected CHARGE on pad 3"); end
    checks++;
    repeat (5) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    if (pad_discharge !== 9'h1FF) begin errors++; $display("FAIL midrst_discharge: got %h expected 1ff", pad_discharge); end
    checks++;
    if (pad_index !== 4'd0) begin errors++; $display("FAIL midrst_index: got %0d expected 0", pad_index); end
    checks++;
    if (sensor_readings !== '0) begin errors++; $display("FAIL midrst_readings: got %h expected 0", sensor_readings); end
    checks++;
    if (scan_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", scan_done); end
    checks++;
    reset = 1'b0;
    scan_enable = 1'b0;
    model_reset();
    repeat (10) @(negedge clock);
    if (pad_index !== 4'd0 || pad_discharge !== 9'h1FF) begin
      errors++; $display("FAIL midrst_idle: got idx %0d dis %h expected idx 0 dis 1ff", pad_index, pad_discharge);
    end
    checks++;
  endtask

  task automatic test_pad0_rise();
    bit ok;
    logic [31:0] p8, c8;
    randomize_pads();
    dly[0]  = 10;
    disc_viol = 0;
    rel0      = 0;
    pulse_enable();
    wait_done(ok, p8, c8);
    model_sweep();
    if (!ok) begin errors++; $display("FAIL pad0_done: got timeout expected scan_done"); end
    checks++;
    if (get_slot(0) !== 32'd12) begin errors++; $display("FAIL pad0_reading: got %0d expected 12", get_slot(0)); end
    checks++;
    repeat (10) @(negedge clock);
    if (rel0 !== exp_raw(0) + 1) begin errors++; $display("FAIL pad0_release_cycles: got %0d expected %0d", rel0, exp_raw(0) + 1); end
    checks++;
    if (disc_viol !== 0) begin errors++; $display("FAIL pad_discipline: got %0d violations expected 0", disc_viol); end
    checks++;
    for (int p = 0; p < NP; p++) begin
      if (get_slot(p) !== model_slot[p]) begin errors++; $display("FAIL pad0_sweep_slot%0d: got %0d expected %0d", p, get_slot(p), model_slot[p]); end
      checks++;
    end
  endtask

  task automatic test_timeout_and_high();
    bit ok;
    logic [31:0] p8, c8;
    pulse_reset();
    randomize_pads();
    mode[5] = M_NEVER;
    mode[7] = M_HIGH;
    mode[8] = M_NEVER;
    pulse_enable();
    wait_done(ok, p8, c8);
    model_sweep();
    if (!ok) begin errors++; $display("FAIL edge_done: got timeout expected scan_done"); end
    checks++;
    if (get_slot(5) !== 32'd100) begin errors++; $display("FAIL timeout_slot5: got %0d expected 100", get_slot(5)); end
    checks++;
    if (get_slot(7) !== 32'd0) begin errors++; $display("FAIL high_slot7: got %0d expected 0", get_slot(7)); end
    checks++;
    for (int p = 0; p < NP; p++) begin
      if (get_slot(p) !== model_slot[p]) begin errors++; $display("FAIL edge_slot%0d: got %0d expected %0d", p, get_slot(p), model_slot[p]); end
      checks++;
    end
  endtask

  task automatic test_full_sweep();
    bit ok;
    int d0;
    logic [31:0] p8, c8, old8;
    for (int p = 0; p < NP; p++) begin
      mode[p] = M_RISE;
      dly[p]  = 5 + p;
    end
    old8 = model_slot[8];
    d0   = done_cnt;
    pulse_enable();
    wait_done(ok, p8, c8);
    model_sweep();
    if (!ok) begin errors++; $display("FAIL full_done: got timeout expected scan_done"); end
    checks++;
    if (p8 !== old8) begin errors++; $display("FAIL full_slot8_before_done: got %0d expected %0d", p8, old8); end
    checks++;
    if (c8 !== model_slot[8]) begin errors++; $display("FAIL full_slot8_at_done: got %0d expected %0d", c8, model_slot[8]); end
    checks++;
    repeat (20) @(negedge clock);
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt - d0); end
    checks++;
`ifndef CAP_FILTER_EN
    for (int p = 1; p < NP; p++) begin
      if (get_slot(p) - get_slot(p-1) !== 32'd1) begin errors++; $display("FAIL full_step%0d: got %0d expected 1", p, get_slot(p) - get_slot(p-1)); end
      checks++;
    end
`endif
    for (int p = 0; p < NP; p++) begin
      if (get_slot(p) !== model_slot[p]) begin errors++; $display("FAIL full_slot%0d: got %0d expected %0d", p, get_slot(p), model_slot[p]); end
      checks++;
    end
  endtask

  task automatic test_drop_mid_sweep();
    bit ok = 1'b0;
    int d0;
    logic [31:0] p8, c8;
    logic [32*NP-1:0] snap;
    randomize_pads();
    d0 = done_cnt;
    @(negedge clock) scan_enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (pad_index === 4'd4) begin ok = 1'b1; break; end
    end
    scan_enable = 1'b0;
    if (!ok) begin errors++; $display("FAIL drop_reach_pad4: got timeout expected pad_index 4"); end
    checks++;
    wait_done(ok, p8, c8);
    model_sweep();
    if (!ok) begin errors++; $display("FAIL drop_done: got timeout expected scan_done"); end
    checks++;
    for (int p = 0; p < NP; p++) begin
      if (get_slot(p) !== model_slot[p]) begin errors++; $display("FAIL drop_slot%0d: got %0d expected %0d", p, get_slot(p), model_slot[p]); end
      checks++;
    end
    repeat (30) @(negedge clock);
    if (pad_index !== 4'd0 || pad_discharge !== 9'h1FF) begin
      errors++; $display("FAIL drop_idle: got idx %0d dis %h expected idx 0 dis 1ff", pad_index, pad_discharge);
    end
    checks++;
    snap = sensor_readings;
    repeat (150) @(negedge clock);
    if (sensor_readings !== snap) begin errors++; $display("FAIL drop_no_writes: got %h expected %h", sensor_readings, snap); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL drop_done_pulses: got %0d expected 1", done_cnt - d0); end
    checks++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d0;
    logic [31:0] p8, c8;
    randomize_pads();
    mode[$urandom_range(0, NP-1)] = M_NEVER;
    d0 = done_cnt;
    @(negedge clock) scan_enable = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) scan_enable = 1'b0;
      wait_done(ok, p8, c8);
      model_sweep();
      if (!ok) begin errors++; $display("FAIL b2b_done%0d: got timeout expected scan_done", s); end
      checks++;
      for (int p = 0; p < NP; p++) begin
        if (get_slot(p) !== model_slot[p]) begin errors++; $display("FAIL b2b_sweep%0d_slot%0d: got %0d expected %0d", s, p, get_slot(p), model_slot[p]); end
        checks++;
      end
    end
    repeat (30) @(negedge clock);
    if (done_cnt - d0 !== 4) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 4", done_cnt - d0); end
    checks++;
    if (pad_index !== 4'd0) begin errors++; $display("FAIL b2b_idle_index: got %0d expected 0", pad_index); end
    checks++;
  endtask

  task automatic test_pad2_sequence();
    bit ok;
    logic [31:0] p8, c8;
    logic [31:0] want2;
    pulse_reset();
    randomize_pads();
    dly[2] = 38;
    pulse_enable();
    wait_done(ok, p8, c8);
    model_sweep();
    if (!ok || get_slot(2) !== 32'd40) begin errors++; $display("FAIL seq_slot2_first: got %0d expected 40", get_slot(2)); end
    checks++;
    dly[2] = 78;
    pulse_enable();
    wait_done(ok, p8, c8);
    model_sweep();
`ifdef CAP_FILTER_EN
    want2 = 32'd50;
`else
    want2 = 32'd80;
`endif
    if (!ok || get_slot(2) !== want2) begin errors++; $display("FAIL seq_slot2_second: got %0d expected %0d", get_slot(2), want2); end
    checks++;
    for (int p = 0; p < NP; p++) begin
      if (get_slot(p) !== model_slot[p]) begin errors++; $display("FAIL seq_slot%0d: got %0d expected %0d", p, get_slot(p), model_slot[p]); end
      checks++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    scan_enable = 1'b0;
    for (int p = 0; p < NP; p++) begin
      mode[p] = M_RISE;
      dly[p]  = p;
    end
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_reset_mid_charge();
    test_pad0_rise();
    test_timeout_and_high();
    test_full_sweep();
    test_drop_mid_sweep();
    test_back_to_back();
    test_pad2_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cap_sense_scanner.md
Name: cap_sense_scanner

Overview:
- Producer end of the capacitive-sensing path. Sequentially measures RC charge time on NUM_PADS touch pads.
- Publishes one 32-bit reading per pad on a packed bus consumed by the execute stage's cap instruction. Pad i occupies bits [32*i+31:32*i].
- Sits at the top level between the pad I/O (tristate discharge drivers plus pull-up resistors) and the processor.

Parameters:
- NUM_PADS, 9, number of pads scanned; the packed bus is 32*NUM_PADS wide.
- DISCHARGE_CYCLES, 64, cycles a pad is held low before each measurement (>=1).
- COUNT_MAX, 65535, charge-count timeout; a reading saturates here (<2^32).

Ports:
- clock  in  1  system clock. Only clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- scan_enable  in  1  level; while high, sweeps repeat continuously.
- pad_in  in  NUM_PADS  raw (asynchronous) pad levels.
- pad_discharge  out  NUM_PADS  1 = drive pad low; 0 = release (pull-up charges it).
- sensor_readings  out  32*NUM_PADS  latest reading per pad.
- pad_index  out  4  pad currently being measured.
- scan_done  out  1  one-cycle pulse after the last pad's reading is written.

Behaviour:
- Reset (async) values:
  - state=IDLE, pad_index=0, counter=0.
  - pad_discharge = all ones.
  - sensor_readings = 0, scan_done = 0.
  - Synchronizer flops = 0.
- Synchronizer: pad_in passes through 2 flops before use. The sync latency is included in the count.
- Pad discipline:
  - Every pad other than pad_index has pad_discharge=1 at all times.
  - pad_discharge[pad_index] is 0 only in CHARGE.
- FSM states IDLE, DISCHARGE, CHARGE, STORE:
  - IDLE: pad_index=0. If scan_enable, go to DISCHARGE and load counter=0.
  - DISCHARGE: counter increments each cycle. At counter==DISCHARGE_CYCLES-1, go to CHARGE with counter=0.
  - CHARGE: in each cycle where synced pad_in[pad_index]==0 and counter<COUNT_MAX, counter++. Go to STORE when synced bit==1 or counter==COUNT_MAX.
  - STORE: write counter into slot pad_index; the value is visible on sensor_readings the next cycle.
    - If pad_index==NUM_PADS-1: pulse scan_done in the same cycle as the write, and set pad_index=0. Go to DISCHARGE if scan_enable, else IDLE.
    - Otherwise: pad_index++ and go to DISCHARGE, regardless of scan_enable.
- Consequences:
  - Deasserting scan_enable mid-sweep completes the sweep.
  - A pad already high at release reads 0.
  - A pad that never charges reads COUNT_MAX.
- Per-pad latency = DISCHARGE_CYCLES + reading + 1 (STORE) cycles.
- Slots not being written hold their value. Readings are never cleared except by reset.
- Reset mid-measurement aborts immediately to the reset values. The partial count is discarded.
- Widths: counter is 32 bits and compares against COUNT_MAX without wrap. pad_index never exceeds NUM_PADS-1.

Optional Feature:
- Macro CAP_FILTER_EN.
- Defined:
  - STORE writes slot = (3*old + new) >> 2, computed at 34 bits and truncated to 32.
  - Exception: the first store to each pad after reset loads new directly. A per-pad valid bit, reset to 0, tracks this.
  - Adds one register stage: the slot updates 2 cycles after STORE, and scan_done delays by one cycle to stay coincident.
- Undefined: raw count is written as specified above. No valid bits.

Decomposition:
- Shared package (cap_sense_pkg):
  - READING_W=32.
  - Default NUM_PADS=9.
  - FSM state encoding (2-bit localparams IDLE/DISCHARGE/CHARGE/STORE).
  - Slot-offset helper constant for the 32*i packing, shared with the execute-stage decode.
- Sub-module: cap_pad_sync, a NUM_PADS-wide 2-flop synchronizer with async reset. All other logic stays in one module.

Test Plan (DISCHARGE_CYCLES=4, COUNT_MAX=100, NUM_PADS=9):
- Reset asserted mid-CHARGE on pad 3 -> next cycle pad_discharge=9'h1FF, pad_index=0, all readings 0, scan_done=0.
- Pad 0 model rises 10 cycles after release, scan_enable=1 -> slot0 reads the 10 cycles plus 2 sync cycles per the count rule (checker computes the exact value from the model). pad_discharge[0]=0 only during CHARGE. Every other pad_discharge bit stays 1 throughout.
- Pad 5 held low forever -> slot5 = 100 (timeout). Pad 7 held high -> slot7 = 0.
- Full sweep with pads i charging after 5+i cycles -> exactly one scan_done pulse, coincident with the slot8 write. Readings increase monotonically by 1 across slots.
- Drop scan_enable while on pad 4 -> pads 4..8 still written, one scan_done, then IDLE with pad_index=0 and no further writes.
- CAP_FILTER_EN, pad 2 sequence of raw 40 then 80 -> slot2 = 40 after sweep 1, then (120+80)>>2 = 50 after sweep 2.
